// File: rtl/booth_mul_radix4_seq.sv
// Iterative radix-4 Booth multiplier. It retires two multiplier bits per clock and handles signed or
// unsigned operands. Valid/ready handshakes sit on both sides, and it returns the full 2*W product.
module booth_mul_radix4_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      is_signed,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic                      busy
);

    localparam int W  = DATA_WIDTH;
    localparam int N  = W / 2 + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W+2:0]    a_r;
    logic [W+1:0]    q_r;
    logic            q_m1_r;
    logic [W+1:0]    m_r;
    logic [CW-1:0]   cnt_r;
    logic [2*W-1:0]  product_r;
    logic            out_valid_r;

    logic            accept_s;
    logic            consume_s;
    logic            last_iter_s;
    logic [W+2:0]    m_ext_s;
    logic [W+2:0]    sum_s;
    logic [W+2:0]    a_nxt_s;
    logic [W+1:0]    q_nxt_s;

    // Widen an operand to W+2 bits so the top Booth digit sees the right sign in both modes.
    function automatic logic [W+1:0] ext_op(input logic [W-1:0] v, input logic sgn);
        return {{2{sgn & v[W-1]}}, v};
    endfunction

    // Booth digit selection over {Q[1],Q[0],q_m1}.
    function automatic logic [W+2:0] booth_term(input logic [2:0] dig, input logic [W+2:0] m1);
        logic [W+2:0] t;
        case (dig)
            3'b001, 3'b010: t = m1;
            3'b011:         t = m1 << 1;
            3'b100:         t = {(W+3){1'b0}} - (m1 << 1);
            3'b101, 3'b110: t = {(W+3){1'b0}} - m1;
            default:        t = {(W+3){1'b0}};
        endcase
        return t;
    endfunction

    assign in_ready    = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s    = in_valid & in_ready;
    assign consume_s   = out_valid_r & out_ready;
    assign last_iter_s = (state_r == RUN) && (cnt_r == CW'(N - 1));
    assign out_valid   = out_valid_r;
    assign product     = product_r;
    assign busy        = (state_r == RUN);

    // One Booth step: add the selected term, then arithmetic-shift {A,Q,q_m1} right by two.
    always_comb begin
        m_ext_s = {m_r[W+1], m_r};
        sum_s   = a_r + booth_term({q_r[1:0], q_m1_r}, m_ext_s);
        a_nxt_s = {{2{sum_s[W+2]}}, sum_s[W+2:2]};
        q_nxt_s = {sum_s[1:0], q_r[W+1:2]};
    end

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (consume_s && accept_s) begin
                    state_nxt_s = RUN;
                end else if (consume_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= '0;
            q_r         <= '0;
            q_m1_r      <= 1'b0;
            m_r         <= '0;
            cnt_r       <= '0;
            product_r   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                a_r    <= '0;
                q_r    <= ext_op(multiplier, is_signed);
                m_r    <= ext_op(multiplicand, is_signed);
                q_m1_r <= 1'b0;
                cnt_r  <= '0;
            end else if (state_r == RUN) begin
                a_r    <= a_nxt_s;
                q_r    <= q_nxt_s;
                q_m1_r <= q_r[1];
                cnt_r  <= cnt_r + CW'(1);
            end
            // The product only moves on entry to DONE, so it is stable while a result waits.
            if (last_iter_s) begin
                product_r   <= {a_nxt_s[W-3:0], q_nxt_s};
                out_valid_r <= 1'b1;
            end else if (consume_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_radix4_seq.sv
// Scoreboard bench for booth_mul_radix4_seq: the driver queues expected products at accept and the
// monitor pops them as results are consumed.
module tb_booth_mul_radix4_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic [31:0] multiplicand = 32'h0;
    logic [31:0] multiplier = 32'h0;
    logic        out_valid;
    wire         out_ready;
    logic [63:0] product;
    logic        busy;

    logic        ready_dir = 1'b1;
    logic        rnd_en = 1'b0;
    logic        rnd_bit = 1'b1;
    assign out_ready = rnd_en ? rnd_bit : ready_dir;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    booth_mul_radix4_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q, input logic s);
        logic [63:0] a;
        logic [63:0] b;
        a = s ? {{32{m[31]}}, m} : {32'h0, m};
        b = s ? {{32{q[31]}}, q} : {32'h0, q};
        return a * b;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic s,
                         input logic [63:0] req);
        bit got;
        got = 1'b0;
        multiplicand = m;
        multiplier   = q;
        is_signed    = s;
        in_valid     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            exp_q.push_back(req);
            lat_q.push_back(cyc + 1);
        end else begin
            fail_now("accept_wait");
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        is_signed    = ~s;
    endtask

    // Monitor: latency on each rising out_valid, product compare on each consume.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_ov) begin
                if (lat_q.size() > 0) chk("latency", 64'(cyc - lat_q.pop_front()), 64'd17);
                else begin
                    errors++; checks++;
                    $display("FAIL spurious_valid actual=1 required=0");
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) chk("product", product, exp_q.pop_front());
                else begin
                    errors++; checks++;
                    $display("FAIL duplicate_result actual=%h required=none", product);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] hold;
        bit seen;
        logic [31:0] rm, rq;
        logic rs;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_product", product, 64'd0);
        @(posedge clk);
        #1;

        issue(32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFF_FFFFFFD6);
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        issue(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        issue(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000);
        issue(32'h80000000, 32'h00000002, 1'b0, 64'h00000001_00000000);
        issue(32'h00000000, 32'h8000FFFF, 1'b1, 64'h0);
        issue(32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000);
        issue(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000);
        drain();

        // Back-pressure then same-edge consume and accept.
        ready_dir = 1'b0;
        @(posedge clk);
        #1;
        issue(32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("bp_valid_wait");
        hold = product;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_product_stable", product, hold);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_dir = 1'b1;
        issue(32'h00001234, 32'h00000010, 1'b0, 64'h00000000_00012340);
        drain();

        // Reset on the eighth RUN iteration; the in-flight result must never appear.
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E_242D2080);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (25) @(negedge clk);
        chk("abort_no_result", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E_242D2080);
        drain();

        // Random operands and modes with random consumer stalls.
        rnd_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            rm = $urandom;
            rq = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (k % 10 == 0) rm = 32'h80000000;
            if (k % 13 == 0) rq = 32'hFFFFFFFF;
            issue(rm, rq, rs, ref_mul(rm, rq, rs));
        end
        drain();
        rnd_en = 1'b0;
        chk("latency_queue_empty", 64'(lat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
